ysyx_22040237_regfile_sb: RTL

Integer register file with a write-pending scoreboard. It is the consumer end of the writeback interface: it accepts rd_wr_en/rd_idx/rd_data from the writeback unit. It serves two decode-stage read ports. It tracks outstanding destination writes, so decode can detect RAW hazards before issuing an instruction.

---
 rtl/ysyx_22040237_regfile_sb_pkg.sv | 24 ++
 rtl/ysyx_22040237_sb_cnt.sv | 78 +++++++
 rtl/ysyx_22040237_regfile_sb.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040237_regfile_sb_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22040237_regfile_sb_pkg
// Shared sizing constants and types for the register file / scoreboard slice.
//   DEF_REG_WIDTH : register data width (taken from `ysyx_22040237_REG_WIDTH,
//                   64 unless the build overrides the macro)
//   IDX_W         : architectural register index width
//   DEF_NREG      : number of architectural registers (x0 hardwired to zero)
//   DEF_CNT_W     : width of each per-register pending-write counter
// Optional feature elsewhere in the slice: YSYX_22040237_REGFILE_BYPASS_EN.
// ---------------------------------------------------------------------------
`ifndef ysyx_22040237_REG_WIDTH
`define ysyx_22040237_REG_WIDTH 64
`endif

package ysyx_22040237_regfile_sb_pkg;

    localparam int DEF_REG_WIDTH = `ysyx_22040237_REG_WIDTH;
    localparam int IDX_W         = 5;
    localparam int DEF_NREG      = 32;
    localparam int DEF_CNT_W     = 2;

    typedef logic [IDX_W-1:0] reg_idx_t;

endpackage

// File: rtl/ysyx_22040237_sb_cnt.sv
// ---------------------------------------------------------------------------
// ysyx_22040237_sb_cnt
// Pending-write counter for one architectural register.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   flush_i   : clear the count, ignoring inc/dec this cycle
//   inc_i     : an instruction writing this register is issuing
//   dec_i     : writeback to this register is retiring
//   cnt_o     : current outstanding-write count (registered)
//   err_o     : pulse, writeback arrived while no write was outstanding
// The count never wraps: the issuer stalls at all-ones, and a retire at zero
// holds the count at zero and raises err_o instead.
// ---------------------------------------------------------------------------
module ysyx_22040237_sb_cnt
    import ysyx_22040237_regfile_sb_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             err_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next-count selection: flush first, then the inc/dec combinations.
    always_comb begin
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else begin
            case ({inc_i, dec_i})
                2'b10: begin
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                2'b01: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Underflow detection; a flushed cycle discards the retire entirely.
    always_comb begin
        err_o = 1'b0;
        if (!flush_i && dec_i && (cnt_q == '0)) begin
            err_o = 1'b1;
        end else begin
            err_o = 1'b0;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ysyx_22040237_regfile_sb.sv
// ---------------------------------------------------------------------------
// ysyx_22040237_regfile_sb
// Integer register file with a write-pending scoreboard.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   rd_wr_en_i/rd_idx_i/rd_data_i : writeback write port (x0 writes dropped)
//   rs1_idx_i/rs2_idx_i           : decode read indices
//   rs1_data_o/rs2_data_o         : combinational read data (x0 reads 0)
//   rs1_busy_o/rs2_busy_o         : read register has an outstanding write
//   issue_en_i/issue_rd_idx_i     : issuing instruction and its destination
//   issue_stall_o                 : destination counter saturated, hold issue
//   flush_i                       : drop all pending-write tracking
//   busy_vec_o                    : per-register busy bits
//   sb_err_o                      : sticky, writeback with nothing pending
// Macro YSYX_22040237_REGFILE_BYPASS_EN: forward same-cycle writeback data
// to the read ports and report busy from the post-retire count.
// ---------------------------------------------------------------------------
module ysyx_22040237_regfile_sb
    import ysyx_22040237_regfile_sb_pkg::*;
#(
    parameter int REG_WIDTH = DEF_REG_WIDTH,
    parameter int NREG      = DEF_NREG,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rd_wr_en_i,
    input  logic [4:0]           rd_idx_i,
    input  logic [REG_WIDTH-1:0] rd_data_i,
    input  logic [4:0]           rs1_idx_i,
    input  logic [4:0]           rs2_idx_i,
    output logic [REG_WIDTH-1:0] rs1_data_o,
    output logic [REG_WIDTH-1:0] rs2_data_o,
    output logic                 rs1_busy_o,
    output logic                 rs2_busy_o,
    input  logic                 issue_en_i,
    input  logic [4:0]           issue_rd_idx_i,
    output logic                 issue_stall_o,
    input  logic                 flush_i,
    output logic [NREG-1:0]      busy_vec_o,
    output logic                 sb_err_o
);

    logic [REG_WIDTH-1:0] regs_q [NREG];
    logic [CNT_W-1:0]     cnt_s  [NREG];
    logic [NREG-1:0]      inc_vec_s;
    logic [NREG-1:0]      dec_vec_s;
    logic [NREG-1:0]      err_vec_s;
    logic [NREG-1:0]      busy_s;
    logic [CNT_W-1:0]     issue_cnt_s;
    logic                 sb_err_q;
    logic                 sb_err_d;
`ifdef YSYX_22040237_REGFILE_BYPASS_EN
    logic [NREG-1:0]      busy_post_s;
`endif

    // A retire to the issuing register frees a slot, so saturation only
    // stalls when no same-cycle writeback targets that register.
    always_comb begin
        issue_cnt_s   = cnt_s[issue_rd_idx_i];
        issue_stall_o = 1'b0;
        if (issue_en_i && (issue_rd_idx_i != 5'd0) &&
            (issue_cnt_s == {CNT_W{1'b1}}) &&
            !(rd_wr_en_i && (rd_idx_i == issue_rd_idx_i))) begin
            issue_stall_o = 1'b1;
        end else begin
            issue_stall_o = 1'b0;
        end
    end

    // Per-register increment/decrement strobes and busy bits; x0 never tracks.
    always_comb begin
        inc_vec_s = '0;
        dec_vec_s = '0;
        busy_s    = '0;
        for (int i = 1; i < NREG; i++) begin
            inc_vec_s[i] = issue_en_i && (issue_rd_idx_i == 5'(i)) && !issue_stall_o;
            dec_vec_s[i] = rd_wr_en_i && (rd_idx_i == 5'(i));
            busy_s[i]    = (cnt_s[i] != '0);
        end
    end

    assign cnt_s[0]     = '0;
    assign err_vec_s[0] = 1'b0;

    for (genvar g = 1; g < NREG; g++) begin : g_cnt
        ysyx_22040237_sb_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .rst     (rst),
            .flush_i (flush_i),
            .inc_i   (inc_vec_s[g]),
            .dec_i   (dec_vec_s[g]),
            .cnt_o   (cnt_s[g]),
            .err_o   (err_vec_s[g])
        );
    end

`ifdef YSYX_22040237_REGFILE_BYPASS_EN
    // Busy as seen after this cycle's retire: inc+dec leaves the count alone,
    // a lone retire drops it by one.
    always_comb begin
        busy_post_s = '0;
        for (int i = 1; i < NREG; i++) begin
            if (inc_vec_s[i]) begin
                busy_post_s[i] = (cnt_s[i] != '0);
            end else begin
                busy_post_s[i] = (cnt_s[i] > {{(CNT_W-1){1'b0}}, 1'b1});
            end
        end
    end
`endif

    // Read ports, with optional same-cycle writeback forwarding.
    always_comb begin
        rs1_data_o = (rs1_idx_i == 5'd0) ? '0 : regs_q[rs1_idx_i];
        rs2_data_o = (rs2_idx_i == 5'd0) ? '0 : regs_q[rs2_idx_i];
        rs1_busy_o = busy_s[rs1_idx_i];
        rs2_busy_o = busy_s[rs2_idx_i];
`ifdef YSYX_22040237_REGFILE_BYPASS_EN
        if (rd_wr_en_i && (rd_idx_i != 5'd0) && (rd_idx_i == rs1_idx_i)) begin
            rs1_data_o = rd_data_i;
            rs1_busy_o = busy_post_s[rs1_idx_i];
        end else begin
            rs1_busy_o = busy_s[rs1_idx_i];
        end
        if (rd_wr_en_i && (rd_idx_i != 5'd0) && (rd_idx_i == rs2_idx_i)) begin
            rs2_data_o = rd_data_i;
            rs2_busy_o = busy_post_s[rs2_idx_i];
        end else begin
            rs2_busy_o = busy_s[rs2_idx_i];
        end
`endif
    end

    assign busy_vec_o = busy_s;

    // Register array; x0 is never written so it stays at its reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (rd_wr_en_i && (rd_idx_i != 5'd0)) begin
            regs_q[rd_idx_i] <= rd_data_i;
        end
    end

    // Sticky error: any counter underflow latches until reset.
    always_comb begin
        sb_err_d = sb_err_q;
        if (|err_vec_s) begin
            sb_err_d = 1'b1;
        end else begin
            sb_err_d = sb_err_q;
        end
    end

    // Error flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_err_q <= 1'b0;
        end else begin
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err_o = sb_err_q;

endmodule
